// File: rtl/float_to_int.sv
// Multi-cycle float32 -> signed int32 converter with stb/ack handshakes on both sides.
// Define FTOI_ROUND_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module float_to_int #(
  parameter logic [31:0] INVALID_VALUE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [2:0] GET_A   = 3'd0;
  localparam logic [2:0] UNPACK  = 3'd1;
  localparam logic [2:0] SPECIAL = 3'd2;
  localparam logic [2:0] CONVERT = 3'd3;
  localparam logic [2:0] PUT_Z   = 3'd4;

`ifdef FTOI_ROUND_EN
  // e = -1 still rounds up to 1 when the fraction exceeds one half
  localparam logic signed [9:0] ZERO_LIMIT = -10'sd1;
`else
  localparam logic signed [9:0] ZERO_LIMIT = 10'sd0;
`endif

  logic [2:0]        state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       m_q, m_d;
  logic signed [9:0] e_q, e_d;
  logic              s_q, s_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [31:0]       z_q, z_d;
  logic              ack_q, ack_d;
  logic [31:0]       out_z_q, out_z_d;
  logic              out_stb_q, out_stb_d;
  logic              round_inc;
  logic [31:0]       rounded;

`ifdef FTOI_ROUND_EN
  assign round_inc = guard_q & (sticky_q | m_q[0]);
`else
  assign round_inc = 1'b0;
`endif

  assign rounded = m_q + {31'd0, round_inc};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    e_d       = e_q;
    s_d       = s_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    z_d       = z_q;
    ack_d     = 1'b0;
    out_z_d   = out_z_q;
    out_stb_d = out_stb_q;

    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        m_d      = {1'b1, a_q[22:0], 8'd0};
        e_d      = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        s_d      = a_q[31];
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        state_d  = SPECIAL;
      end

      SPECIAL: begin
        if (e_q > 10'sd30) begin
          z_d     = INVALID_VALUE;
          state_d = PUT_Z;
        end else if (e_q < ZERO_LIMIT) begin
          z_d     = '0;
          state_d = PUT_Z;
        end else begin
          state_d = CONVERT;
        end
      end

      CONVERT: begin
        if (e_q < 10'sd31) begin
          e_d      = e_q + 10'sd1;
          m_d      = m_q >> 1;
          guard_d  = m_q[0];
          sticky_d = sticky_q | guard_q;
        end else begin
          z_d     = s_q ? -rounded : rounded;
          state_d = PUT_Z;
        end
      end

      PUT_Z: begin
        out_stb_d = 1'b1;
        out_z_d   = z_q;
        if (out_stb_q && output_z_ack) begin
          out_stb_d = 1'b0;
          state_d   = GET_A;
        end
      end

      default: begin
        out_stb_d = 1'b0;
        state_d   = GET_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GET_A;
      a_q       <= '0;
      m_q       <= '0;
      e_q       <= '0;
      s_q       <= 1'b0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      z_q       <= '0;
      ack_q     <= 1'b0;
      out_z_q   <= '0;
      out_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      e_q       <= e_d;
      s_q       <= s_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      z_q       <= z_d;
      ack_q     <= ack_d;
      out_z_q   <= out_z_d;
      out_stb_q <= out_stb_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z     = out_z_q;
  assign output_z_stb = out_stb_q;

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed table, handshake/reset sequences, random vs. arithmetic model.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  always #5 clk = ~clk;

  float_to_int #(.INVALID_VALUE(32'h8000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

`ifdef FTOI_ROUND_EN
  localparam int MIN_E = -1;
`else
  localparam int MIN_E = 0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Value-level model: magnitude = mant * 2^(e-23), then truncate or round half to even.
  function automatic logic [31:0] ref_conv(input logic [31:0] x);
    int      e;
    int      sh;
    longint  mant;
    longint  mag;
    longint  r;
`ifdef FTOI_ROUND_EN
    longint  rem;
    longint  half;
`endif
    e    = int'(x[30:23]) - 127;
    mant = longint'({1'b1, x[22:0]});
    if (e > 30) return 32'h8000_0000;
    if (e < MIN_E) return 32'h0;
    if (e >= 23) begin
      mag = mant << (e - 23);
    end else begin
      sh  = 23 - e;
      mag = mant >> sh;
`ifdef FTOI_ROUND_EN
      rem  = mant - (mag << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && mag[0])) mag = mag + 1;
`endif
    end
    r = x[31] ? -mag : mag;
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] x);
    int e;
    e = int'(x[30:23]) - 127;
    if (e > 30 || e < MIN_E) return -1;
    return 35 - e;
  endfunction

  task automatic run_txn(input logic [31:0] val, input int ack_delay,
                         output logic [31:0] res, output int lat, output bit ok);
    int n;
    ok  = 1'b1;
    res = '0;
    lat = -1;
    input_a     = val;
    input_a_stb = 1'b1;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (input_a_ack !== 1'b1) begin
      check("accept_timeout", 32'(input_a_ack), 32'd1);
      input_a_stb = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = $urandom;
    lat = 0;
    while (output_z_stb !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (output_z_stb !== 1'b1) begin
      check("result_timeout", 32'(output_z_stb), 32'd1);
      ok = 1'b0;
      return;
    end
    res = output_z;
    check("no_overlap_ack", 32'(input_a_ack), 32'd0);
    for (int i = 0; i < ack_delay; i++) begin
      @(posedge clk); #1;
      check("hold_stb", 32'(output_z_stb), 32'd1);
      check("hold_z", output_z, res);
      check("hold_in_ack", 32'(input_a_ack), 32'd0);
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check("stb_drop", 32'(output_z_stb), 32'd0);
  endtask

  typedef struct {
    logic [31:0] in;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] res;
    int          lat;
    bit          ok;
    logic [31:0] val;
    int          n;

    vecs[0]  = '{32'h3F80_0000, 32'h0000_0001};
    vecs[1]  = '{32'hBF80_0000, 32'hFFFF_FFFF};
    vecs[2]  = '{32'hC2F6_E979, 32'hFFFF_FF85};
`ifdef FTOI_ROUND_EN
    vecs[3]  = '{32'h3FC0_0000, 32'h0000_0002};
    vecs[5]  = '{32'h3F40_0000, 32'h0000_0001};
    vecs[14] = '{32'h3F7F_FFFF, 32'h0000_0001};
    vecs[15] = '{32'hBF40_0000, 32'hFFFF_FFFF};
`else
    vecs[3]  = '{32'h3FC0_0000, 32'h0000_0001};
    vecs[5]  = '{32'h3F40_0000, 32'h0000_0000};
    vecs[14] = '{32'h3F7F_FFFF, 32'h0000_0000};
    vecs[15] = '{32'hBF40_0000, 32'h0000_0000};
`endif
    vecs[4]  = '{32'h4020_0000, 32'h0000_0002};
    vecs[6]  = '{32'h3F00_0000, 32'h0000_0000};
    vecs[7]  = '{32'h4F00_0000, 32'h8000_0000};
    vecs[8]  = '{32'h7F80_0000, 32'h8000_0000};
    vecs[9]  = '{32'h7FC0_0000, 32'h8000_0000};
    vecs[10] = '{32'h4EFF_FFFF, 32'h7FFF_FF80};
    vecs[11] = '{32'h0000_0001, 32'h0000_0000};
    vecs[12] = '{32'h8000_0000, 32'h0000_0000};
    vecs[13] = '{32'hCF00_0000, 32'h8000_0000};

    rst          = 1'b1;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 32'(input_a_ack), 32'd0);
    check("reset_stb", 32'(output_z_stb), 32'd0);
    check("reset_z", output_z, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ack_after_reset", 32'(input_a_ack), 32'd1);

    for (int i = 0; i < 16; i++) begin
      run_txn(vecs[i].in, 0, res, lat, ok);
      if (ok) begin
        check($sformatf("vec%0d_z", i), res, vecs[i].exp);
        if (ref_lat(vecs[i].in) >= 0)
          check($sformatf("vec%0d_lat", i), 32'(lat), 32'(ref_lat(vecs[i].in)));
      end
    end

    // Backpressure: hold ack low for 10 cycles, then release handshake timing
    run_txn(32'hC2F6_E979, 10, res, lat, ok);
    if (ok) begin
      check("bp_z", res, 32'hFFFF_FF85);
      check("bp_in_ack_low", 32'(input_a_ack), 32'd0);
      @(posedge clk); #1;
      check("bp_in_ack_rise", 32'(input_a_ack), 32'd1);
    end

    // Reset in the middle of CONVERT drops the transaction
    run_txn(32'h3F80_0000, 0, res, lat, ok);
    input_a     = 32'h3F80_0000;
    input_a_stb = 1'b1;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("rst_seq_accept", 32'(input_a_ack), 32'd1);
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_stb", 32'(output_z_stb), 32'd0);
    check("midrst_ack", 32'(input_a_ack), 32'd0);
    check("midrst_z", output_z, 32'd0);
    @(posedge clk); #1;
    check("midrst_ack_rise", 32'(input_a_ack), 32'd1);
    run_txn(32'h4020_0000, 0, res, lat, ok);
    if (ok) check("post_rst_z", res, 32'h0000_0002);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7)
        val = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 160)), 23'($urandom)};
      else
        val = $urandom;
      run_txn(val, int'($urandom_range(0, 2)), res, lat, ok);
      if (ok) begin
        check($sformatf("rand_z[%08h]", val), res, ref_conv(val));
        if (ref_lat(val) >= 0)
          check($sformatf("rand_lat[%08h]", val), 32'(lat), 32'(ref_lat(val)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
